// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op codes and FSM states shared by shift_unit and shift_step
package shift_pkg;

  typedef enum logic [2:0] {
    OP_CLEAR = 3'b000,
    OP_LOAD  = 3'b001,
    OP_LSR   = 3'b010,
    OP_LSL   = 3'b011,
    OP_ASR   = 3'b100,
    OP_SERIN = 3'b101,
    OP_ROR   = 3'b110,
    OP_ROL   = 3'b111
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

  function automatic logic is_rotate(shift_op_t op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter for shift_unit
// Rotates are only implemented when SHIFT_UNIT_ROTATE_EN is defined; otherwise they pass Q through.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  shift_op_t          i_op,
  input  logic [WIDTH-1:0]   i_q,
  input  logic               i_serial_in,
  output logic [WIDTH-1:0]   o_next
);

  always_comb begin
    o_next = i_q;
    case (i_op)
      OP_LSR:   o_next = {1'b0, i_q[WIDTH-1:1]};
      OP_LSL:   o_next = {i_q[WIDTH-2:0], 1'b0};
      OP_ASR:   o_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
      OP_SERIN: o_next = {i_serial_in, i_q[WIDTH-1:1]};
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR:   o_next = {i_q[0], i_q[WIDTH-1:1]};
      OP_ROL:   o_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
`endif
      default:  o_next = i_q;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle shift register unit with valid/ready command and result handshakes
// Optional feature macro: SHIFT_UNIT_ROTATE_EN (rotates enabled; err port removed when defined).
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [AW-1:0]     amount,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              serial_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [WIDTH-1:0]  q,
  output logic              busy
`ifndef SHIFT_UNIT_ROTATE_EN
  ,
  output logic              err
`endif
);

  localparam logic [AW:0] W_LIMIT = (AW+1)'(WIDTH);

  shift_state_t     r_state, w_state_next;
  shift_op_t        r_op;
  shift_op_t        w_op;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_amt;
  logic [WIDTH-1:0] r_q, r_out, w_next;
  logic             w_accept, w_direct, w_rot_unsup;

  assign w_op     = shift_op_t'(op);
  assign w_accept = in_valid && in_ready;
  assign w_amt    = ({1'b0, amount} >= W_LIMIT) ? AW'(WIDTH - 1) : amount;

`ifdef SHIFT_UNIT_ROTATE_EN
  assign w_rot_unsup = 1'b0;
`else
  assign w_rot_unsup = is_rotate(w_op);
`endif

  // Commands that finish without entering SHIFT
  assign w_direct = (w_op == OP_CLEAR) || (w_op == OP_LOAD) || (w_amt == '0) || w_rot_unsup;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_op        (r_op),
    .i_q         (r_q),
    .i_serial_in (serial_in),
    .o_next      (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = w_direct ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (r_cnt == AW'(1)) w_state_next = ST_DONE;
      ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_out <= '0;
      r_cnt <= '0;
      r_op  <= OP_CLEAR;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          case (w_op)
            OP_CLEAR: begin r_q <= '0;        r_out <= '0;        end
            OP_LOAD:  begin r_q <= load_data; r_out <= load_data; end
            default: begin
              r_op  <= w_op;
              r_cnt <= w_direct ? '0 : w_amt;
              if (w_direct) r_out <= r_q;
            end
          endcase
        end
        ST_SHIFT: begin
          r_q   <= w_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == AW'(1)) r_out <= w_next;
        end
        default: ;
      endcase
    end
  end

`ifndef SHIFT_UNIT_ROTATE_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst)                                 r_err <= 1'b0;
    else if (r_state == ST_IDLE && w_accept) r_err <= w_rot_unsup;
    else if (r_state == ST_DONE && out_ready) r_err <= 1'b0;
  end
  assign err = r_err;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_out;
  assign q         = r_q;

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - directed vector bench for shift_unit (WIDTH=8)
// Expectations adapt to SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, serial_in, out_valid, out_ready, busy;
  logic [2:0] op, amount;
  logic [7:0] load_data, out_data, q;
  logic       err_w;

  int n_app = 0;
  int n_err = 0;
  logic [7:0] trace [0:40];

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .amount(amount), .load_data(load_data), .serial_in(serial_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .q(q), .busy(busy)
`ifndef SHIFT_UNIT_ROTATE_EN
    , .err(err_w)
`endif
  );
`ifdef SHIFT_UNIT_ROTATE_EN
  assign err_w = 1'b0;
`endif

  typedef struct {
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] ld;
    logic [7:0] bits;
    logic [7:0] exp_data;
    int         exp_lat;
    logic       exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_app++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] o, input logic [2:0] a, input logic [7:0] ld,
                         input logic [7:0] bits, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; amount = a; load_data = ld; serial_in = bits[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    trace[1] = q;
    while (!out_valid && lat < 40) begin
      if (lat <= 8) serial_in = bits[lat-1];
      @(posedge clk); #1;
      lat++;
      trace[lat] = q;
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, ".in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int vcount;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; serial_in = 1'b0;
    op = 3'b000; amount = '0; load_data = '0;

    //        op      amt   ld     bits   exp    lat  err
    vecs.push_back('{3'b001, 3'd0, 8'hA5, 8'h00, 8'hA5, 1, 1'b0});
    vecs.push_back('{3'b000, 3'd5, 8'h00, 8'h00, 8'h00, 1, 1'b0});
    vecs.push_back('{3'b001, 3'd0, 8'h81, 8'h00, 8'h81, 1, 1'b0});
`ifdef SHIFT_UNIT_ROTATE_EN
    vecs.push_back('{3'b111, 3'd1, 8'h00, 8'h00, 8'h03, 2, 1'b0});
    vecs.push_back('{3'b001, 3'd0, 8'h81, 8'h00, 8'h81, 1, 1'b0});
    vecs.push_back('{3'b110, 3'd2, 8'h00, 8'h00, 8'h60, 3, 1'b0});
`else
    vecs.push_back('{3'b111, 3'd1, 8'h00, 8'h00, 8'h81, 1, 1'b1});
    vecs.push_back('{3'b001, 3'd0, 8'h81, 8'h00, 8'h81, 1, 1'b0});
    vecs.push_back('{3'b110, 3'd2, 8'h00, 8'h00, 8'h81, 1, 1'b1});
`endif
    vecs.push_back('{3'b000, 3'd0, 8'h00, 8'h00, 8'h00, 1, 1'b0});
    vecs.push_back('{3'b101, 3'd4, 8'h00, 8'h0D, 8'hD0, 5, 1'b0});
    vecs.push_back('{3'b011, 3'd0, 8'h00, 8'h00, 8'hD0, 1, 1'b0});
    vecs.push_back('{3'b011, 3'd2, 8'h00, 8'h00, 8'h40, 3, 1'b0});
    vecs.push_back('{3'b010, 3'd7, 8'h00, 8'h00, 8'h00, 8, 1'b0});
    vecs.push_back('{3'b001, 3'd0, 8'h96, 8'h00, 8'h96, 1, 1'b0});
    vecs.push_back('{3'b010, 3'd1, 8'h00, 8'h00, 8'h4B, 2, 1'b0});
    vecs.push_back('{3'b001, 3'd0, 8'hB6, 8'h00, 8'hB6, 1, 1'b0});
    vecs.push_back('{3'b100, 3'd7, 8'h00, 8'h00, 8'hFF, 8, 1'b0});
`ifdef SHIFT_UNIT_ROTATE_EN
    vecs.push_back('{3'b111, 3'd0, 8'h00, 8'h00, 8'hFF, 1, 1'b0});
`else
    vecs.push_back('{3'b111, 3'd0, 8'h00, 8'h00, 8'hFF, 1, 1'b1});
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.q", 64'(q), 64'h0);
    chk("reset.out_data", 64'(out_data), 64'h0);
    chk("reset.err", 64'(err_w), 64'd0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].amt, vecs[i].ld, vecs[i].bits, lat);
      chk($sformatf("vec%0d.latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d.out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
      chk($sformatf("vec%0d.err", i), 64'(err_w), 64'(vecs[i].exp_err));
      handshake($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.err_clear", i), 64'(err_w), 64'd0);
    end

    // ASR with visible intermediate steps
    run_cmd(3'b001, 3'd0, 8'h81, 8'h00, lat);
    handshake("asr_load");
    run_cmd(3'b100, 3'd3, 8'h00, 8'h00, lat);
    chk("asr.latency", 64'(lat), 64'd4);
    chk("asr.step1", 64'(trace[2]), 64'hC0);
    chk("asr.step2", 64'(trace[3]), 64'hE0);
    chk("asr.step3", 64'(trace[4]), 64'hF0);
    chk("asr.out_data", 64'(out_data), 64'hF0);
    handshake("asr");

    // backpressure in DONE with a competing command offered
    run_cmd(3'b001, 3'd0, 8'h3C, 8'h00, lat);
    in_valid = 1'b1; op = 3'b001; load_data = 8'h77;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d.out_data", k), 64'(out_data), 64'h3C);
      chk($sformatf("bp%0d.out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d.in_ready", k), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    @(posedge clk); #1;
    chk("bp.q_not_loaded", 64'(q), 64'h3C);
    chk("bp.no_queued", 64'(out_valid), 64'd0);

    // reset in the middle of a shift
    run_cmd(3'b001, 3'd0, 8'hFF, 8'h00, lat);
    handshake("abort_load");
    @(negedge clk);
    in_valid = 1'b1; op = 3'b010; amount = 3'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort.mid_q", 64'(q), 64'h3F);
    chk("abort.busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.q", 64'(q), 64'h0);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.out_data", 64'(out_data), 64'h0);
    rst = 1'b0;
    seen = 1'b0;
    vcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
      vcount++;
    end
    chk("abort.no_result", 64'(seen), 64'd0);
    chk("abort.idle_cycles", 64'(vcount), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
    $finish;
  end

endmodule
